// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: single-outstanding request FSM with static branch
// prediction, redirect handling and a one-entry instruction buffer to decode.
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_dnpc_i,
  input  logic        jump_flush_i,
  input  logic [31:0] jump_dnpc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        drop_q, drop_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] imm_j, imm_b, pred_off, pred_npc;
  logic [31:0] inst;

  assign inst   = imem_resp_data_i;
  assign redir  = flush_i | jump_flush_i;
  assign target = flush_i ? {flush_dnpc_i[31:1], 1'b0} : {jump_dnpc_i[31:1], 1'b0};

  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

  // Backward branches are predicted taken, JAL always taken, everything else falls through.
  always_comb begin
    pred_off = 32'd4;
    if (inst[6:2] == 5'b11011) begin
      pred_off = imm_j;
    end else if (inst[6:2] == 5'b11000 && inst[31]) begin
      pred_off = imm_b;
    end
  end

  assign pred_npc = pc_q + pred_off;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    drop_d     = drop_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_d = S_WAIT;
          drop_d  = redir;
        end
        if (redir) pc_d = target;
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          if (drop_q || redir) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d    = S_HOLD;
            out_pc_d   = pc_q;
            out_inst_d = inst;
            npc_d      = {pred_npc[31:1], 1'b0};
          end
        end else if (redir) begin
          drop_d = 1'b1;
        end
        if (redir) pc_d = target;
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
          pc_d    = target;
        end else if (out_ready_i) begin
          state_d = S_REQ;
          pc_d    = npc_q;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_REQ;
      pc_q       <= {RESET_PC[31:1], 1'b0};
      npc_q      <= {RESET_PC[31:1], 1'b0};
      drop_q     <= 1'b0;
      out_pc_q   <= 32'd0;
      out_inst_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      drop_q     <= drop_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
    end
  end

  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_addr_o      = pc_q;
  assign out_valid_o      = (state_q == S_HOLD);
  assign out_pc_o         = out_pc_q;
  assign out_inst_o       = out_inst_q;

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for the fetch unit: reset, prediction, redirects, stall and reset mid-fetch.
module tb_ysyx_23060203_ifu;

  logic        clock_i = 1'b0;
  logic        reset_ni;
  logic        flush_i;
  logic [31:0] flush_dnpc_i;
  logic        jump_flush_i;
  logic [31:0] jump_dnpc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  int checks = 0;
  int errors = 0;

  ysyx_23060203_ifu dut (
    .clock_i           (clock_i),
    .reset_ni          (reset_ni),
    .flush_i           (flush_i),
    .flush_dnpc_i      (flush_dnpc_i),
    .jump_flush_i      (jump_flush_i),
    .jump_dnpc_i       (jump_dnpc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_pc_o          (out_pc_o),
    .out_inst_o        (out_inst_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock_i);
  endtask

  // From REQ: handshake, one idle cycle, then the response; leaves the DUT in HOLD.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = data;
    step();
    imem_resp_valid_i = 1'b0;
  endtask

  task automatic redirect_jump(input logic [31:0] dnpc);
    jump_flush_i = 1'b1;
    jump_dnpc_i  = dnpc;
    step();
    jump_flush_i = 1'b0;
  endtask

  task automatic accept();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  // Fetch one instruction at pc, accept it and check the predicted next address.
  task automatic pred_case(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [31:0] exp_npc);
    redirect_jump(pc);
    fetch(inst);
    chk({tag, "_pc"}, out_pc_o, pc);
    accept();
    chk({tag, "_npc"}, imem_addr_o, exp_npc);
  endtask

  initial begin
    reset_ni          = 1'b0;
    flush_i           = 1'b0;
    flush_dnpc_i      = 32'd0;
    jump_flush_i      = 1'b0;
    jump_dnpc_i       = 32'd0;
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = 32'd0;
    out_ready_i       = 1'b0;
    step();
    step();
    chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("rst_addr", imem_addr_o, 32'h3000_0000);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_pc", out_pc_o, 32'd0);
    chk("rst_out_inst", out_inst_o, 32'd0);

    // First fetch after reset
    reset_ni = 1'b1;
    step();
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk("wait_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    step();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0000_0013;
    step();
    imem_resp_valid_i = 1'b0;
    chk("first_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("first_out_pc", out_pc_o, 32'h3000_0000);
    chk("first_out_inst", out_inst_o, 32'h0000_0013);
    chk("hold_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    accept();
    chk("first_npc", imem_addr_o, 32'h3000_0004);
    chk("after_acc_valid", {31'd0, out_valid_o}, 32'd0);
    chk("after_acc_req", {31'd0, imem_req_valid_o}, 32'd1);

    // Static prediction
    pred_case("beq_back", 32'h3000_0010, 32'hFE00_0EE3, 32'h3000_000C);
    pred_case("jal_fwd", 32'h3000_0020, 32'h0080_006F, 32'h3000_0028);
    pred_case("beq_fwd", 32'h3000_0040, 32'h0000_0463, 32'h3000_0044);
    pred_case("jalr", 32'h3000_0050, 32'h0000_80E7, 32'h3000_0054);
    pred_case("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000);

    // Redirect target bit 0 forced low
    redirect_jump(32'h3000_0061);
    chk("bit0_clear", imem_addr_o, 32'h3000_0060);

    // Redirect while WAIT, response later is dropped
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    redirect_jump(32'h3000_0100);
    chk("wait_redir_outv", {31'd0, out_valid_o}, 32'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0000_0013;
    step();
    imem_resp_valid_i = 1'b0;
    chk("drop_outv", {31'd0, out_valid_o}, 32'd0);
    chk("drop_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("drop_addr", imem_addr_o, 32'h3000_0100);

    // Redirect and response in the same WAIT cycle
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i  = 1'b0;
    imem_resp_valid_i = 1'b1;
    jump_flush_i      = 1'b1;
    jump_dnpc_i       = 32'h3000_0180;
    step();
    imem_resp_valid_i = 1'b0;
    jump_flush_i      = 1'b0;
    chk("same_cyc_outv", {31'd0, out_valid_o}, 32'd0);
    chk("same_cyc_addr", imem_addr_o, 32'h3000_0180);
    chk("same_cyc_req", {31'd0, imem_req_valid_o}, 32'd1);

    // Redirect together with the request handshake
    imem_req_ready_i = 1'b1;
    jump_flush_i     = 1'b1;
    jump_dnpc_i      = 32'h3000_01C0;
    step();
    imem_req_ready_i = 1'b0;
    jump_flush_i     = 1'b0;
    chk("req_redir_wait", {31'd0, imem_req_valid_o}, 32'd0);
    imem_resp_valid_i = 1'b1;
    step();
    imem_resp_valid_i = 1'b0;
    chk("req_redir_outv", {31'd0, out_valid_o}, 32'd0);
    chk("req_redir_addr", imem_addr_o, 32'h3000_01C0);

    // Both redirects in HOLD with out_ready high: flush wins
    fetch(32'h0000_0013);
    chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
    out_ready_i  = 1'b1;
    flush_i      = 1'b1;
    flush_dnpc_i = 32'h3000_0200;
    jump_flush_i = 1'b1;
    jump_dnpc_i  = 32'h3000_0100;
    step();
    out_ready_i  = 1'b0;
    flush_i      = 1'b0;
    jump_flush_i = 1'b0;
    chk("prio_outv", {31'd0, out_valid_o}, 32'd0);
    chk("prio_addr", imem_addr_o, 32'h3000_0200);

    // Decode stall in HOLD
    fetch(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_outv", {31'd0, out_valid_o}, 32'd1);
      chk("stall_pc", out_pc_o, 32'h3000_0200);
      chk("stall_inst", out_inst_o, 32'h1234_5678);
      chk("stall_req", {31'd0, imem_req_valid_o}, 32'd0);
    end
    accept();
    chk("stall_npc", imem_addr_o, 32'h3000_0204);

    // Reset while a request is outstanding
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    #1 reset_ni = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("mid_rst_addr", imem_addr_o, 32'h3000_0000);
    chk("mid_rst_outv", {31'd0, out_valid_o}, 32'd0);
    step();
    reset_ni = 1'b1;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = 32'h0000_0013;
    step();
    imem_resp_valid_i = 1'b0;
    chk("late_resp_outv", {31'd0, out_valid_o}, 32'd0);
    chk("late_resp_req", {31'd0, imem_req_valid_o}, 32'd1);
    chk("late_resp_addr", imem_addr_o, 32'h3000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
